// File: rtl/port_master_if.sv
// port_master_if: core-side request/response bundle for port_master.
interface port_master_if;
  logic       req_valid, req_ready, req_write, rsp_valid, busy;
  logic [7:0] req_wdata, rsp_rdata;
  modport master(output req_valid, req_write, req_wdata, input req_ready, rsp_valid, rsp_rdata, busy);
  modport slave(input req_valid, req_write, req_wdata, output req_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/port_master.sv
// port_master: single-byte initiator for the 8-bit latch port (ce/z strobes, tristate dio).
// Define PORT_MASTER_TURN_EN to insert a one-cycle bus turnaround before write data is driven.
module port_master #(
  parameter int SETUP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  port_master_if.slave  bus,
  output logic          port_ce,
  output logic          port_z,
  inout  wire  [7:0]    port_dio
);
  typedef enum logic [2:0] {IDLE, TURN, SETUP, LATCH, SAMPLE, DONE} state_t;
  localparam logic [3:0] LOAD = 4'(SETUP_CYCLES - 1);
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       wr, wr_n, oe;
  logic [7:0] wdata, wdata_n, rdata_n;
  assign port_dio = oe ? wdata : 8'bz;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = wr;
    wdata_n = wdata;
    rdata_n = bus.rsp_rdata;
    case (state)
      IDLE: if (bus.req_valid) begin
        wr_n    = bus.req_write;
        wdata_n = bus.req_wdata;
        cnt_n   = LOAD;
`ifdef PORT_MASTER_TURN_EN
        state_n = bus.req_write ? TURN : SETUP;
`else
        state_n = SETUP;
`endif
      end
      TURN:  state_n = SETUP;
      SETUP: begin
        state_n = cnt == 4'd0 ? LATCH : SETUP;
        cnt_n   = cnt == 4'd0 ? cnt : cnt - 4'd1;
      end
      LATCH: begin
        state_n = wr ? DONE : SAMPLE;
        rdata_n = wr ? wdata : bus.rsp_rdata;
      end
      SAMPLE: begin
        state_n = DONE;
        rdata_n = port_dio;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      wr            <= 1'b0;
      wdata         <= 8'h00;
      oe            <= 1'b0;
      port_ce       <= 1'b0;
      port_z        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'h00;
      bus.busy      <= 1'b0;
      bus.req_ready <= 1'b1;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      wr            <= wr_n;
      wdata         <= wdata_n;
      oe            <= wr_n && (state_n == SETUP || state_n == LATCH);
      port_ce       <= state_n == LATCH;
      port_z        <= wr_n && state_n != IDLE;
      bus.rsp_valid <= state_n == DONE;
      bus.rsp_rdata <= rdata_n;
      bus.busy      <= state_n != IDLE;
      bus.req_ready <= state_n == IDLE;
    end
  end
endmodule
